// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: round-robin burst arbiter merging NUM_REQ valid/ready streams into one registered output stream
module stream_rr_arbiter #(
    parameter int num_bits  = 64,
    parameter int NUM_REQ   = 4,
    parameter int BURST_LEN = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*num_bits-1:0] req_data,
    output logic [NUM_REQ-1:0]          req_rdy,
    output logic                        m_valid,
    input  logic                        m_rdy,
    output logic [num_bits-1:0]         m_data,
    output logic [$clog2(NUM_REQ)-1:0]  m_src,
    output logic                        busy
);
    localparam int SW = $clog2(NUM_REQ);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state;
    logic [SW-1:0]       g;
    logic [SW-1:0]       rr_ptr;
    logic [SW-1:0]       sel;
    logic [SW-1:0]       g_next;
    logic [7:0]          beat_cnt;
    logic                rdy_g;
    logic                xfer;
    logic                done;
    logic [num_bits-1:0] slice [NUM_REQ];

    genvar i;
    for (i = 0; i < NUM_REQ; i++) begin : g_slice
        assign slice[i] = req_data[i*num_bits +: num_bits];
    end

    // first valid requester at or above rr_ptr, wrapping; lowest offset wins
    always_comb begin
        sel = rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[SW'((int'(rr_ptr) + k) % NUM_REQ)]) sel = SW'((int'(rr_ptr) + k) % NUM_REQ);
        end
    end

    // granted requester may push when the output register is empty or draining
    always_comb begin
        rdy_g   = (state == GRANT) && (!m_valid || m_rdy);
        xfer    = rdy_g && req_valid[g];
        done    = (xfer && beat_cnt == 8'(BURST_LEN - 1)) || (rdy_g && !req_valid[g]);
        g_next  = (g == SW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
        req_rdy = rdy_g ? (NUM_REQ'(1) << g) : '0;
    end

    // arbitration FSM together with the output register it feeds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            g        <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            busy     <= 1'b0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_src    <= '0;
        end else begin
            if (xfer) begin
                m_data  <= slice[g];
                m_src   <= g;
                m_valid <= 1'b1;
            end else if (m_valid && m_rdy) begin
                m_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        state    <= GRANT;
                        g        <= sel;
                        beat_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                GRANT: begin
                    if (xfer) beat_cnt <= beat_cnt + 8'd1;
                    if (done) begin
                        state  <= IDLE;
                        rr_ptr <= g_next;
                        busy   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: directed vector table, corner sequences and a randomized model check for stream_rr_arbiter
module tb_stream_rr_arbiter;
    localparam int N = 4;
    localparam int W = 64;
    localparam int B = 4;

    logic           clk = 0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_rdy;
    logic           m_valid;
    logic           m_rdy;
    logic [W-1:0]   m_data;
    logic [1:0]     m_src;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int seq [N];
    logic [W-1:0] sink [$];

    stream_rr_arbiter #(.num_bits(W), .NUM_REQ(N), .BURST_LEN(B)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_rdy(req_rdy), .m_valid(m_valid), .m_rdy(m_rdy), .m_data(m_data),
        .m_src(m_src), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] beat(int src, int s);
        return {24'h0, 8'(src), 32'(s)};
    endfunction

    // each requester streams an incrementing counter tagged with its index
    always_comb begin
        req_data = '0;
        for (int r = 0; r < N; r++) req_data[r*W +: W] = beat(r, seq[r]);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < N; r++) seq[r] <= 0;
        end else begin
            for (int r = 0; r < N; r++) if (req_valid[r] && req_rdy[r]) seq[r] <= seq[r] + 1;
        end
    end

    always @(posedge clk) if (!rst && m_valid && m_rdy) sink.push_back(m_data);

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        req_valid = '0;
        m_rdy = 1'b1;
        @(posedge clk);
        #1;
        rst = 0;
        sink.delete();
    endtask

    typedef struct {
        logic [3:0] valid;
        logic       rdy;
        logic [3:0] e_rdy;
        logic       e_mv;
        logic       e_busy;
        int         e_src;
        int         e_seq;
    } vec_t;

    vec_t vecs [12];

    // reference model state: granted index (-1 when idle), pointer, beats, output register
    int mg, mptr, mbeats, ms, nexp [N];
    bit mv;
    logic [W-1:0] md;

    initial begin
        vecs[0]  = '{4'b1010, 1'b1, 4'b0000, 1'b0, 1'b0, 0, 0};
        vecs[1]  = '{4'b1010, 1'b1, 4'b0010, 1'b0, 1'b1, 0, 0};
        vecs[2]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 1'b1, 1, 0};
        vecs[3]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 1'b1, 1, 1};
        vecs[4]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 1'b1, 1, 2};
        vecs[5]  = '{4'b1010, 1'b1, 4'b0000, 1'b1, 1'b0, 1, 3};
        vecs[6]  = '{4'b1010, 1'b1, 4'b1000, 1'b0, 1'b1, 0, 0};
        vecs[7]  = '{4'b1010, 1'b1, 4'b1000, 1'b1, 1'b1, 3, 0};
        vecs[8]  = '{4'b1010, 1'b1, 4'b1000, 1'b1, 1'b1, 3, 1};
        vecs[9]  = '{4'b1010, 1'b1, 4'b1000, 1'b1, 1'b1, 3, 2};
        vecs[10] = '{4'b1010, 1'b1, 4'b0000, 1'b1, 1'b0, 3, 3};
        vecs[11] = '{4'b1010, 1'b1, 4'b0010, 1'b0, 1'b1, 0, 0};

        rst = 1;
        req_valid = '0;
        m_rdy = 1'b1;
        #3;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_rdy", req_rdy, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_src", m_src, 0);

        do_reset();
        for (int v = 0; v < 12; v++) begin
            req_valid = vecs[v].valid;
            m_rdy = vecs[v].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d_req_rdy", v), req_rdy, vecs[v].e_rdy);
            chk($sformatf("vec%0d_m_valid", v), m_valid, vecs[v].e_mv);
            chk($sformatf("vec%0d_busy", v), busy, vecs[v].e_busy);
            if (vecs[v].e_mv) begin
                chk($sformatf("vec%0d_m_src", v), m_src, vecs[v].e_src);
                chk($sformatf("vec%0d_m_data", v), m_data, beat(vecs[v].e_src, vecs[v].e_seq));
            end
            nxt();
        end

        // output stall while requester 2 holds the grant
        do_reset();
        req_valid = 4'b0100;
        nxt();
        nxt();
        m_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_req_rdy", req_rdy, 0);
            chk("stall_m_valid", m_valid, 1);
            chk("stall_m_data", m_data, beat(2, 0));
            chk("stall_m_src", m_src, 2);
            nxt();
        end
        m_rdy = 1'b1;
        for (int c = 0; c < 10; c++) nxt();
        req_valid = '0;
        for (int c = 0; c < 3; c++) nxt();
        chk("stall_enough_beats", sink.size() >= 4, 1);
        for (int k = 0; k < sink.size(); k++) chk($sformatf("stall_beat%0d", k), sink[k], beat(2, k));

        // requester 0 goes idle after two beats
        do_reset();
        req_valid = 4'b0011;
        nxt();
        nxt();
        nxt();
        req_valid = 4'b0010;
        @(negedge clk);
        chk("drop_rdy_while_idle_req", req_rdy, 4'b0001);
        chk("drop_beats_taken", seq[0], 2);
        nxt();
        @(negedge clk);
        chk("drop_idle_busy", busy, 0);
        chk("drop_idle_rdy", req_rdy, 0);
        nxt();
        @(negedge clk);
        chk("drop_next_grant", req_rdy, 4'b0010);
        chk("drop_next_busy", busy, 1);

        // reset in the middle of beat 3
        do_reset();
        req_valid = 4'b1111;
        nxt();
        nxt();
        nxt();
        #2;
        rst = 1;
        #1;
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_req_rdy", req_rdy, 0);
        chk("midrst_m_data", m_data, 0);
        @(posedge clk);
        #1;
        rst = 0;
        req_valid = 4'b0110;
        @(negedge clk);
        chk("midrst_idle_rdy", req_rdy, 0);
        nxt();
        @(negedge clk);
        chk("midrst_first_grant", req_rdy, 4'b0010);
        chk("midrst_first_busy", busy, 1);

        // randomized traffic against the reference model
        do_reset();
        mg = -1; mptr = 0; mbeats = 0; mv = 0; md = '0; ms = 0;
        for (int r = 0; r < N; r++) nexp[r] = 0;
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] erdy;
            bit rg, xf;
            for (int r = 0; r < N; r++) req_valid[r] = ($urandom_range(0, 3) != 0);
            m_rdy = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            rg = (mg >= 0) && (!mv || m_rdy);
            erdy = rg ? (N'(1) << mg) : '0;
            chk("rand_req_rdy", req_rdy, erdy);
            chk("rand_m_valid", m_valid, mv);
            chk("rand_busy", busy, mg >= 0);
            if (mv) begin
                chk("rand_m_data", m_data, md);
                chk("rand_m_src", m_src, ms);
            end
            if (m_valid && m_rdy) begin
                chk("rand_tag", m_data[39:32], m_src);
                chk("rand_order", m_data[31:0], nexp[m_src]);
                nexp[m_src]++;
            end
            xf = rg && req_valid[mg];
            if (xf) begin
                md = beat(mg, seq[mg]);
                ms = mg;
                mv = 1;
            end else if (mv && m_rdy) begin
                mv = 0;
            end
            if (mg < 0) begin
                for (int k = N - 1; k >= 0; k--) if (req_valid[(mptr + k) % N]) mg = (mptr + k) % N;
                mbeats = 0;
            end else begin
                if (xf) mbeats++;
                if ((xf && mbeats == B) || (rg && !req_valid[mg])) begin
                    mptr = (mg + 1) % N;
                    mg = -1;
                end
            end
            nxt();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stream_rr_arbiter.md
STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 SHALL have parameter num_bits, default 64, the data width of every stream.
REQ-002 SHALL have parameter NUM_REQ, default 4, the requester count, legal range 2..8.
REQ-003 SHALL have parameter BURST_LEN, default 4, the maximum beats per grant, legal range 1..255.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, NUM_REQ bits: bit i is the valid of requester i.
REQ-007 SHALL have port req_data, input, NUM_REQ*num_bits bits: requester i occupies bits [i*num_bits +: num_bits].
REQ-008 SHALL have port req_rdy, output, NUM_REQ bits: bit i is the ready to requester i.
REQ-009 SHALL have port m_valid, output, 1 bit: merged-stream valid, driving the firmware s1i_valid.
REQ-010 SHALL have port m_rdy, input, 1 bit: merged-stream ready, from the firmware s1i_rdy.
REQ-011 SHALL have port m_data, output, num_bits bits: merged-stream data.
REQ-012 SHALL have port m_src, output, clog2(NUM_REQ) bits: the index of the requester that produced m_data.
REQ-013 SHALL have port busy, output, 1 bit: high while the FSM is in GRANT.

Function
REQ-014 SHALL implement an FSM with two states:
- IDLE: no requester granted.
- GRANT: exactly one requester g granted.
REQ-015 In IDLE with any req_valid high, SHALL select g as the first requester with req_valid high, searching upward from rr_ptr modulo NUM_REQ.
REQ-016 On the IDLE selection in REQ-015, SHALL enter GRANT on the next edge with beat_cnt cleared to 0.
REQ-017 Arbitration SHALL cost one IDLE cycle per grant; req_rdy SHALL be all-zero in IDLE.
REQ-018 In GRANT, SHALL drive req_rdy[g] = (!m_valid || m_rdy) and all other req_rdy bits 0.
REQ-019 A transfer SHALL occur when req_valid[g] && req_rdy[g] in the same cycle.
REQ-020 On each transfer, SHALL on the next edge:
- load m_data from req_data slice g;
- set m_src to g and m_valid to 1;
- increment beat_cnt.
REQ-021 SHALL hold m_data and m_src stable while m_valid && !m_rdy.
REQ-022 When m_valid && m_rdy and no transfer occurs, SHALL clear m_valid on the next edge and hold m_data.
REQ-023 A simultaneous m_rdy drain and new transfer SHALL give back-to-back beats: m_valid stays 1 and the new data loads.
REQ-024 Latency SHALL be one cycle from a requester transfer to m_valid/m_data.
REQ-025 Throughput SHALL be one beat per cycle within a grant while m_rdy stays high.
REQ-026 GRANT SHALL exit to IDLE on the edge following either:
- (a) the transfer that makes beat_cnt equal BURST_LEN; or
- (b) a cycle with req_rdy[g]=1 and req_valid[g]=0, i.e. the requester went idle.
REQ-027 A cycle with req_rdy[g]=0 (output stalled) SHALL NOT end the grant.
REQ-028 On GRANT exit, SHALL set rr_ptr to (g+1) modulo NUM_REQ, wrapping from NUM_REQ-1 to 0.
REQ-029 beat_cnt SHALL be 8 bits and SHALL never exceed BURST_LEN.
REQ-030 A requester dropping req_valid while req_rdy[g]=0 SHALL be legal, with no transfer and no data loss.
REQ-031 Requesters not granted SHALL see req_rdy=0 regardless of m_rdy.
REQ-032 The output register SHALL remain valid across a grant exit and drain normally.

Reset
REQ-033 While rst is high, SHALL immediately force state=IDLE, rr_ptr=0, beat_cnt=0, m_valid=0, m_data=0, m_src=0, busy=0 and req_rdy=0.
REQ-034 Reset asserted mid-burst SHALL discard the in-flight beat held in the output register.
REQ-035 After rst deasserts, the first arbitration SHALL start from rr_ptr=0.

Verification
REQ-036 Reset, then req_valid=4'b1010 with m_rdy=1 SHALL produce:
- one IDLE cycle, then grant to requester 1 with 4 beats at m_src=1;
- one IDLE cycle, then 4 beats at m_src=3.
REQ-037 With all requesters valid continuously and m_rdy=1, grants SHALL rotate 0,1,2,3,0 at 4 beats each, with m_data matching each requester's counter sequence in order.
REQ-038 Requester 2 granted with m_rdy=0 for 5 cycles after the first beat SHALL cause:
- m_data and m_src to hold;
- req_rdy[2] to stay 0;
- no lost or duplicated beats once m_rdy returns to 1.
REQ-039 Requester 0 granted that drops req_valid after 2 beats SHALL cause the FSM to return to IDLE with rr_ptr=1, while requester 1 is granted next.
REQ-040 rst pulsed during beat 3 of a burst SHALL clear m_valid, busy and req_rdy immediately, and the next grant after release SHALL go to the lowest valid index.
